// File: rtl/serial_latch_pkg.sv
// Shared state encoding and default sizing for the serial latch receiver.
package serial_latch_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_ROWS  = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCHED = 2'd2,
    DISPLAY = 2'd3
  } state_t;

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detect
// taken from the last stage against its one-cycle-delayed copy.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_r;
  logic         prev_r;

  // synchronizer chain and delayed copy of its output for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {N{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[N-2:0], d};
      prev_r <= sync_r[N-1];
    end
  end

  assign level = sync_r[N-1];
  assign rise  = sync_r[N-1] & ~prev_r;
  assign fall  = ~sync_r[N-1] & prev_r;

endmodule

// File: rtl/serial_latch_rx.sv
// Receives MSB-first rows from a CLKimpr/DO/LAT/STB transmitter, latches them
// into row_data with a wrapping row index, and drives oe during the strobe.
module serial_latch_rx
  import serial_latch_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ROWS        = DEF_ROWS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLKimpr,
  input  logic                    DO,
  input  logic                    LAT,
  input  logic                    STB,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        row_data,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    row_valid,
  output logic                    oe,
  output logic                    len_err,
  output logic                    seq_err
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int IW = $clog2(ROWS);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [IW-1:0] ROW_LAST = IW'(ROWS - 1);

  logic clk_rise_s, do_lvl_s, lat_rise_s, stb_lvl_s, stb_rise_s, stb_fall_s;
  logic clk_lvl_unused_s, clk_fall_unused_s, do_rise_unused_s, do_fall_unused_s;
  logic lat_lvl_unused_s, lat_fall_unused_s;

  state_t           state_r;
  logic [WIDTH-1:0] sr_r, sr_nxt_s, lat_data_r;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [IW-1:0]    row_cnt_r, lat_idx_r;
  logic             lat_pend_r, len_evt_s, seq_evt_s;

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(CLK), .rst(RST), .d(CLKimpr),
    .level(clk_lvl_unused_s), .rise(clk_rise_s), .fall(clk_fall_unused_s));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_do (
    .clk(CLK), .rst(RST), .d(DO),
    .level(do_lvl_s), .rise(do_rise_unused_s), .fall(do_fall_unused_s));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_lat (
    .clk(CLK), .rst(RST), .d(LAT),
    .level(lat_lvl_unused_s), .rise(lat_rise_s), .fall(lat_fall_unused_s));
  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_stb (
    .clk(CLK), .rst(RST), .d(STB),
    .level(stb_lvl_s), .rise(stb_rise_s), .fall(stb_fall_s));

  // next shift-register/count values and the error events of this cycle
  always_comb begin
    sr_nxt_s  = sr_r;
    cnt_nxt_s = cnt_r;
    seq_evt_s = 1'b0;
    if (clk_rise_s) begin
      sr_nxt_s  = {sr_r[WIDTH-2:0], do_lvl_s};
      cnt_nxt_s = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CW'(1);
    end else begin
      sr_nxt_s  = sr_r;
      cnt_nxt_s = cnt_r;
    end
    len_evt_s = lat_rise_s & (cnt_nxt_s != CNT_FULL);
    case (state_r)
      IDLE, SHIFT: seq_evt_s = stb_rise_s;
      DISPLAY:     seq_evt_s = lat_rise_s;
      default:     seq_evt_s = 1'b0;
    endcase
  end

  // datapath: latch captures the post-shift value, output stage follows a cycle later
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_r       <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      row_cnt_r  <= {IW{1'b0}};
      lat_data_r <= {WIDTH{1'b0}};
      lat_idx_r  <= {IW{1'b0}};
      lat_pend_r <= 1'b0;
      row_data   <= {WIDTH{1'b0}};
      row_idx    <= {IW{1'b0}};
      row_valid  <= 1'b0;
      len_err    <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      sr_r       <= sr_nxt_s;
      lat_pend_r <= lat_rise_s;
      row_valid  <= lat_pend_r;
      if (lat_rise_s) begin
        cnt_r      <= {CW{1'b0}};
        lat_data_r <= sr_nxt_s;
        lat_idx_r  <= row_cnt_r;
        row_cnt_r  <= (row_cnt_r == ROW_LAST) ? {IW{1'b0}} : row_cnt_r + IW'(1);
      end else begin
        cnt_r <= cnt_nxt_s;
      end
      if (lat_pend_r) begin
        row_data <= lat_data_r;
        row_idx  <= lat_idx_r;
      end
      len_err <= (len_err & ~err_clr) | len_evt_s;
      seq_err <= (seq_err & ~err_clr) | seq_evt_s;
    end
  end

  // control FSM with registered output enable
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      oe      <= 1'b0;
    end else begin
      oe <= 1'b0;
      case (state_r)
        IDLE: begin
          if (lat_rise_s)      state_r <= LATCHED;
          else if (clk_rise_s) state_r <= SHIFT;
          else                 state_r <= IDLE;
        end
        SHIFT: begin
          if (lat_rise_s) state_r <= LATCHED;
          else            state_r <= SHIFT;
        end
        LATCHED: begin
          if (stb_rise_s) begin
            state_r <= DISPLAY;
            oe      <= stb_lvl_s;
          end else if (lat_rise_s) begin
            state_r <= LATCHED;
          end else if (clk_rise_s) begin
            state_r <= SHIFT;
          end else begin
            state_r <= LATCHED;
          end
        end
        DISPLAY: begin
          if (stb_fall_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= DISPLAY;
            oe      <= stb_lvl_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_latch_rx.sv
// Directed bench for serial_latch_rx: pin-level transmitter model, row scoreboard
// and sticky-error model.
module tb_serial_latch_rx;

  localparam int WIDTH = 64;
  localparam int ROWS  = 6;
  localparam int SS    = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1, CLKimpr = 1'b0, DO = 1'b0, LAT = 1'b0, STB = 1'b0, err_clr = 1'b0;
  logic [WIDTH-1:0] row_data;
  logic [2:0]       row_idx;
  logic             row_valid, oe, len_err, seq_err;

  int         checks = 0;
  int         errors = 0;
  logic [66:0] exp_q[$];
  logic [66:0] mon_e;
  logic [63:0] sr_m = 64'd0;
  int          cnt_m = 0;
  int          row_m = 0;
  logic        len_m = 1'b0, seq_m = 1'b0;
  logic [63:0] v;
  int          lat_cyc;

  always #5 CLK = ~CLK;

  serial_latch_rx #(.WIDTH(WIDTH), .ROWS(ROWS), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST(RST), .CLKimpr(CLKimpr), .DO(DO), .LAT(LAT), .STB(STB),
    .err_clr(err_clr), .row_data(row_data), .row_idx(row_idx),
    .row_valid(row_valid), .oe(oe), .len_err(len_err), .seq_err(seq_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every row_valid cycle consumes one expected {idx, data}
  always @(negedge CLK) begin
    if (row_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL row_valid_extra observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("row_data", row_data, mon_e[63:0]);
        chk("row_idx", 64'(row_idx), 64'(mon_e[66:64]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_shift(input logic b);
    sr_m = {sr_m[62:0], b};
    if (cnt_m < 65) cnt_m++;
  endtask

  task automatic model_latch();
    exp_q.push_back({3'(row_m), sr_m});
    if (cnt_m != 64) len_m = 1'b1;
    cnt_m = 0;
    row_m = (row_m + 1) % ROWS;
  endtask

  task automatic shift_bit(input logic b);
    DO = b;
    tick(2);
    CLKimpr = 1'b1;
    model_shift(b);
    tick(3);
    CLKimpr = 1'b0;
    tick(3);
  endtask

  task automatic send(input logic [63:0] val, input int n);
    for (int i = 0; i < n; i++) shift_bit(val[63-i]);
  endtask

  task automatic latch();
    model_latch();
    LAT = 1'b1;
    tick(4);
    LAT = 1'b0;
    tick(4);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    len_m = 1'b0;
    seq_m = 1'b0;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, "_len_err"}, 64'(len_err), 64'(len_m));
    chk({tag, "_seq_err"}, 64'(seq_err), 64'(seq_m));
  endtask

  initial begin
    // reset state
    tick(3);
    chk("rst_row_data", row_data, 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_oe", 64'(oe), 64'd0);
    chk_errs("rst");
    RST = 1'b0;
    tick(2);

    // first row, latency from LAT pin to row_valid, then strobe
    send(64'hA5A5_0000_FFFF_1234, 64);
    model_latch();
    LAT = 1'b1;
    lat_cyc = 0;
    for (int k = 1; k <= 10 && lat_cyc == 0; k++) begin
      @(posedge CLK);
      #1;
      if (row_valid === 1'b1) lat_cyc = k;
    end
    chk("latency", 64'(lat_cyc), 64'(SS + 2));
    tick(3);
    LAT = 1'b0;
    tick(4);
    chk("row1_pending", 64'(exp_q.size()), 64'd0);
    STB = 1'b1;
    tick(4);
    chk("row1_oe_on", 64'(oe), 64'd1);
    STB = 1'b0;
    tick(4);
    chk("row1_oe_off", 64'(oe), 64'd0);
    chk_errs("row1");

    // six more rows without strobe: indices 1..5 then wrap to 0
    for (int r = 0; r < 6; r++) begin
      v = {$urandom(), $urandom()};
      send(v, 64);
      latch();
      chk_errs("wrap");
    end

    // short and long rows
    send(64'h1357_9BDF_2468_ACE0, 63);
    latch();
    chk_errs("short");
    clear_errs();
    chk_errs("short_clr");
    send(64'hFEDC_BA98_7654_3210, 64);
    shift_bit(1'b1);
    latch();
    chk_errs("long");
    clear_errs();

    // strobe while shifting: flagged, no output enable
    shift_bit(1'b0);
    STB = 1'b1;
    seq_m = 1'b1;
    tick(4);
    chk("stb_noleat_oe", 64'(oe), 64'd0);
    STB = 1'b0;
    tick(4);
    chk_errs("stb_nolat");
    clear_errs();

    // latch, display, shifts and a latch while strobed
    latch();
    STB = 1'b1;
    tick(4);
    chk("disp_oe", 64'(oe), 64'd1);
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b1);
    chk("disp_shift_oe", 64'(oe), 64'd1);
    seq_m = 1'b1;
    latch();
    chk("disp_lat_oe", 64'(oe), 64'd1);
    chk_errs("disp_lat");
    STB = 1'b0;
    tick(4);
    chk("disp_end_oe", 64'(oe), 64'd0);
    clear_errs();
    chk_errs("disp_clr");

    // simultaneous latch and strobe rise from LATCHED
    send(64'h0F1E_2D3C_4B5A_6978, 64);
    latch();
    STB = 1'b1;
    latch();
    chk("simul_oe", 64'(oe), 64'd1);
    chk_errs("simul");
    STB = 1'b0;
    tick(4);
    clear_errs();

    // last shift edge and latch edge in the same cycle
    v = 64'h0123_4567_89AB_CDEF;
    send(v, 63);
    DO = v[0];
    tick(2);
    CLKimpr = 1'b1;
    LAT = 1'b1;
    model_shift(v[0]);
    model_latch();
    tick(4);
    CLKimpr = 1'b0;
    LAT = 1'b0;
    tick(4);
    chk_errs("same_cycle");

    // reset mid-row discards partial bits and restarts row index
    send(64'hFFFF_FFFF_FFFF_FFFF, 30);
    RST = 1'b1;
    sr_m = 64'd0;
    cnt_m = 0;
    row_m = 0;
    len_m = 1'b0;
    seq_m = 1'b0;
    tick(2);
    chk("midrst_row_data", row_data, 64'd0);
    chk("midrst_row_idx", 64'(row_idx), 64'd0);
    RST = 1'b0;
    tick(2);
    send(64'h0F0F_3C3C_5A5A_9669, 64);
    latch();
    chk_errs("after_rst");

    chk("rows_pending", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_latch_rx.md
SERIAL_LATCH_RX -- requirements
Module: serial_latch_rx

Interface
REQ-001 Parameter WIDTH, default 64: bits per latched row.
REQ-002 Parameter ROWS, default 6: rows per frame; row index wraps after ROWS-1.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on every serial input, minimum 2.
REQ-004 CLK  in  1: the single clock; all state changes on its rising edge.
REQ-005 RST  in  1: reset, asynchronous, active-high.
REQ-006 CLKimpr  in  1: shift clock from the LAT/STB transmitter, asynchronous, period >= 4 CLK periods.
REQ-007 DO  in  1: serial data, stable around CLKimpr rising edges.
REQ-008 LAT  in  1: latch pulse, asynchronous, high >= 2 CLK periods.
REQ-009 STB  in  1: strobe (display enable), asynchronous, high >= 2 CLK periods.
REQ-010 err_clr  in  1: synchronous clear of sticky error flags.
REQ-011 row_data  out  WIDTH: last latched row.
REQ-012 row_idx  out  $clog2(ROWS): index of the row in row_data.
REQ-013 row_valid  out  1: one-cycle pulse when row_data/row_idx update.
REQ-014 oe  out  1: output enable, high while synchronized STB is high in state DISPLAY.
REQ-015 len_err  out  1: sticky; a latch saw a shift count other than WIDTH.
REQ-016 seq_err  out  1: sticky; strobe without a preceding latch, or latch during strobe.

Function
REQ-017 CLKimpr, DO, LAT and STB each SHALL pass through SYNC_STAGES flops before use; rise detect compares last stage with its one-cycle-delayed copy.
REQ-018 On a synchronized CLKimpr rise the shift register SHALL load {sr[WIDTH-2:0], DO_sync}, MSB-first; DO is synchronized with the same depth so the edge and data stay aligned.
REQ-019 Shift counter SHALL increment per shift, saturate at WIDTH+1, and clear on every latch.
REQ-020 FSM states: IDLE, SHIFT, LATCHED, DISPLAY.
REQ-021 IDLE -> SHIFT on first shift; SHIFT -> LATCHED on LAT rise; LATCHED -> DISPLAY on STB rise; DISPLAY -> IDLE on STB fall; LATCHED -> SHIFT on a shift before any STB rise (row latched, no strobe, no error).
REQ-022 LAT rise in any state except DISPLAY: row_data <= sr (including a bit shifted in the same cycle), row_valid = 1 in the following cycle, row_idx <= row counter, counter increments, ROWS-1 wraps to 0.
REQ-023 Latency: row_valid SHALL assert exactly SYNC_STAGES+2 CLK cycles after LAT rises at the pin.
REQ-024 len_err SHALL set on a latch with shift count != WIDTH; a latch with zero shifts SHALL still update row_data and set len_err.
REQ-025 LAT rise while in DISPLAY: seq_err set; latch is still performed; state stays DISPLAY.
REQ-026 STB rise in IDLE or SHIFT: seq_err set; oe stays low; state unchanged.
REQ-027 Shifts during DISPLAY SHALL be accepted into sr and counted; state stays DISPLAY.
REQ-028 err_clr SHALL clear both sticky flags; if an error event occurs in the same cycle, the flag SHALL be set.
REQ-029 Simultaneous LAT rise and STB rise in LATCHED state: latch performed, seq_err not set, transition to DISPLAY.

Reset
REQ-030 RST high SHALL immediately clear all synchronizer flops, sr, shift counter, row counter, row_data, row_idx, row_valid, oe, len_err and seq_err to 0, and set the state to IDLE.
REQ-031 Reset asserted mid-row SHALL discard partial bits; the next latch after release reports row_idx 0.

Structure
REQ-032 Package serial_latch_pkg SHALL hold the state enum and the default WIDTH/ROWS constants.
REQ-033 Sub-module sync_rise SHALL implement a SYNC_STAGES synchronizer plus rise/fall detect; it is instantiated once per serial input (DO uses only the synchronized level).

Verification
REQ-034 Reset, then 64 shifts of 0xA5A5_0000_FFFF_1234 MSB-first, then LAT, then STB -> row_data = 0xA5A5_0000_FFFF_1234, row_idx = 0, one row_valid pulse, oe high for the STB duration, no errors.
REQ-035 Six full rows followed by a seventh -> row_idx sequence 0..5 then 0.
REQ-036 63 shifts then LAT -> len_err = 1; err_clr -> len_err = 0; 65 shifts then LAT -> len_err = 1.
REQ-037 STB pulse with no prior LAT -> seq_err = 1, oe stays 0; LAT during STB high -> seq_err = 1, row_data updated.
REQ-038 Last CLKimpr rise and LAT rise reach the synchronizer outputs in the same cycle -> row_data includes the final bit, len_err = 0.
REQ-039 RST pulse after 30 shifts, then 64 fresh shifts and LAT -> row_data holds only the fresh bits, row_idx = 0, len_err = 0.
